// File: rtl/output_sequencer.sv
// output_sequencer: Moore controller sequencing the shared output counter over one burst of beats.
// Latency: Start at edge k -> Out_valid from cycle k+1; Done in the cycle after the last handshake.
// Backpressure: Out_ready=0 holds state and counter; OUT_SEQ_TIMEOUT_EN adds a stall abort (Err with Done).
module output_sequencer #(
   parameter int CNT_W          = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [CNT_W-1:0] Num_out,
   input  logic [CNT_W-1:0] o_count_in,
   input  logic             Out_ready,
   output logic             En_o_count,
   output logic             Res_o_count,
   output logic             Out_valid,
   output logic             Out_last,
   output logic             Busy,
   output logic             Done,
   output logic             Err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] last_idx;
   logic             handshake;
   logic             at_last;
   logic             stall_expire;

   assign at_last   = (o_count_in == last_idx);
   assign handshake = (state == RUN) && Out_ready;

`ifdef OUT_SEQ_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

   logic [STALL_W-1:0] stall_cnt;
   logic               abort_q;

   // Expires on the TIMEOUT_CYCLES-th consecutive stalled RUN cycle.
   assign stall_expire = (state == RUN) && !Out_ready &&
                         (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         stall_cnt <= '0;
         abort_q   <= 1'b0;
      end else begin
         if ((state != RUN) || Out_ready)
            stall_cnt <= '0;
         else
            stall_cnt <= stall_cnt + 1'b1;
         abort_q <= stall_expire;
      end
   end

   assign Err = (state == FINISH) && abort_q;
`else
   logic unused_timeout;

   assign unused_timeout = |TIMEOUT_CYCLES;
   assign stall_expire   = 1'b0;
   assign Err            = 1'b0;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         last_idx <= '0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && Start)
            last_idx <= Num_out;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = RUN;
         RUN: begin
            if (handshake && at_last)
               state_nxt = FINISH;
            else if (stall_expire)
               state_nxt = FINISH;
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Counter is held in clear outside RUN, so every burst starts at index 0.
   assign Res_o_count = (state == RUN);
   assign Out_valid   = (state == RUN);
   assign Busy        = (state == RUN) || (state == FINISH);
   assign Done        = (state == FINISH);
   assign En_o_count  = handshake;
   assign Out_last    = (state == RUN) && at_last;

endmodule

// File: doc/output_sequencer.md
# output_sequencer

Moore-style controller that sequences the shared 3-bit output counter for one burst of output beats. It drives the counter's enable and active-low clear, and presents a valid/ready handshake to the downstream consumer. It uses the counter value, fed back in, as the beat index. It sits between the top-level control FSM, which issues `Start`, and the output-stage datapath.

## Interface
Parameters:
- `CNT_W`, default 3: width of the counter feedback and of `Num_out`; must match the output counter width.
- `TIMEOUT_CYCLES`, default 16: number of consecutive stalled RUN cycles before abort. Used only with `OUT_SEQ_TIMEOUT_EN`; legal range 2..256.

Ports:
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Start` in 1: burst request; sampled only in IDLE.
- `Num_out` in CNT_W: index of the last beat (beats = `Num_out`+1, so 1..8); latched on accepted `Start`.
- `o_count_in` in CNT_W: current output counter value (feedback).
- `Out_ready` in 1: downstream ready.
- `En_o_count` out 1: counter increment enable.
- `Res_o_count` out 1: counter clear, active-low.
- `Out_valid` out 1: current beat valid.
- `Out_last` out 1: current beat is the final one.
- `Busy` out 1: burst in progress.
- `Done` out 1: one-cycle end-of-burst pulse.
- `Err` out 1: one-cycle abort pulse; tied 0 without the macro.

## Operation
- States: IDLE, RUN, FINISH. Reset forces IDLE and clears `last_idx` and the stall counter.
- Output decode:
  - `Res_o_count` = 0 in IDLE and FINISH, so the counter is held or cleared; it is 1 in RUN.
  - `Busy` = 1 in RUN and FINISH.
  - `Out_valid` = 1 in RUN only.
  - `En_o_count` = RUN & `Out_ready`.
  - `Out_last` = RUN & (`o_count_in` == `last_idx`).
  - `Done` = 1 in FINISH.
- IDLE:
  - On `Start`=1, latch `Num_out` into `last_idx` and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - A handshake (`Out_valid` & `Out_ready`) advances the counter by 1.
  - A handshake with `Out_last`=1 moves to FINISH.
  - With `Out_ready`=0, state, counter and all outputs hold.
- FINISH: lasts one cycle, then returns to IDLE. The counter is cleared at this edge.
- `Start` in RUN or FINISH is ignored and not queued. `Num_out` changes after acceptance have no effect.
- `Num_out`=0 gives a single-beat burst; `Out_last`=1 on the first RUN cycle.
- `Num_out`=7: the counter wraps 7→0 on the last handshake. This is harmless because FINISH clears the counter.
- The counter is external, so `o_count_in` must be 0 on RUN entry. This is guaranteed because IDLE holds `Res_o_count`=0.

## Timing
- Reset value of every output: `En_o_count`=0, `Res_o_count`=0, `Out_valid`=0, `Out_last`=0, `Busy`=0, `Done`=0, `Err`=0.
- Latency:
  - `Start` sampled at edge k gives `Out_valid`=1 from cycle k+1.
  - Last handshake at edge m gives `Done`=1 in cycle m+1.
  - The FSM is back in IDLE, able to accept `Start`, from cycle m+2.
- Minimum burst time with `Out_ready` held at 1: N+2 cycles from `Start` to IDLE, where N = `Num_out`+1.
- `En_o_count` and `Out_last` are combinational from `Out_ready` and `o_count_in`. All other outputs decode registered state.
- `Reset` mid-burst: IDLE at the next edge, no `Done` or `Err` pulse, and the counter is cleared via `Res_o_count`=0.
- `Reset` and `Start` in the same cycle: `Reset` wins.

## Configuration
- Macro: `OUT_SEQ_TIMEOUT_EN`.
- Defined:
  - A stall counter increments on each RUN cycle with `Out_ready`=0 and clears on any handshake.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to FINISH. In that FINISH cycle `Err`=1 together with `Done`=1.
  - The stall counter clears on FINISH and on reset.
- Not defined: no stall counter, `Err` is constant 0, and RUN waits indefinitely for `Out_ready`.

## Test plan
- Reset held 2 cycles with `Start`=1 → all outputs at reset values; FSM still IDLE after release until `Start` is sampled.
- `Num_out`=3, `Out_ready`=1 constant, `Start` pulsed → `Out_valid` for 4 cycles with `o_count_in` 0,1,2,3; `Out_last` only at 3; `Done` the next cycle; counter back to 0.
- `Num_out`=7 with `Out_ready` toggling 1,0,1,0… → exactly 8 handshakes; `En_o_count` only in ready cycles; `Done` after the 8th; wrap 7→0 shows no extra beat.
- `Num_out`=0, plus a `Start` re-pulsed during RUN and FINISH → single beat with `Out_last`=1 immediately; the extra `Start` produces no second burst.
- `Reset` asserted during the third beat of a 6-beat burst → IDLE next edge, `Done`=0, `Res_o_count`=0, counter 0.
- With `OUT_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: `Out_ready`=0 after 2 beats → abort after 16 stalled cycles with `Done`=`Err`=1 for one cycle. Without the macro: the same stimulus holds RUN for 100 cycles and `Err` stays 0.
